// File: rtl/store_check_pkg.sv
// Shared types and constants for the store-bus checker.
// Latency: n/a (declarations only).
// Backpressure: n/a; the checker only observes the bus and never stalls it.
package store_check_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_PASS = 2'd2,
        ST_FAIL = 2'd3
    } state_e;

    localparam logic [1:0] FC_NONE    = 2'd0;
    localparam logic [1:0] FC_DATA    = 2'd1;
    localparam logic [1:0] FC_ADDR    = 2'd2;
    localparam logic [1:0] FC_TIMEOUT = 2'd3;

endpackage

// File: rtl/store_exp_table.sv
// Expected-store register file, match bitmap and parallel address compare.
// Latency: table and bitmap writes land on the next edge; hit/data_ok are combinational.
// Backpressure: none; writes to an index outside the table are dropped.
//
// Ports: wr_* load one entry; clr_map/set_en/set_idx maintain the match
// bitmap; ord_idx selects the one comparable entry in ordered mode;
// st_addr/st_data are the observed store; hit/hit_idx/data_ok/bit_set
// describe the lowest-index entry whose address matches.
module store_exp_table #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int NUM_EXP = 4,
    parameter int IDX_W   = 2,
    parameter bit ORDERED = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [IDX_W-1:0]  wr_idx,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              clr_map,
    input  logic              set_en,
    input  logic [IDX_W-1:0]  set_idx,
    input  logic [IDX_W:0]    ord_idx,
    input  logic [ADDR_W-1:0] st_addr,
    input  logic [DATA_W-1:0] st_data,
    output logic              hit,
    output logic [IDX_W-1:0]  hit_idx,
    output logic              data_ok,
    output logic              bit_set
);

    logic [ADDR_W-1:0]  addr_q [NUM_EXP];
    logic [DATA_W-1:0]  data_q [NUM_EXP];
    logic [NUM_EXP-1:0] map_q;

    // Index decode by loop: an out-of-range wr_idx matches no entry and is dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_EXP; i++) begin
                addr_q[i] <= '0;
                data_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_EXP; i++) begin
                if (wr_en && (wr_idx == IDX_W'(i))) begin
                    addr_q[i] <= wr_addr;
                    data_q[i] <= wr_data;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            map_q <= '0;
        end else if (clr_map) begin
            map_q <= '0;
        end else if (set_en) begin
            for (int i = 0; i < NUM_EXP; i++) begin
                if (set_idx == IDX_W'(i)) begin
                    map_q[i] <= 1'b1;
                end
            end
        end
    end

    // Ordered mode only considers the entry at ord_idx; unordered mode takes
    // the lowest-index address match so duplicate addresses resolve stably.
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        data_ok = 1'b0;
        bit_set = 1'b0;
        for (int i = 0; i < NUM_EXP; i++) begin
            if (!hit && (addr_q[i] == st_addr) &&
                (!ORDERED || (ord_idx == (IDX_W+1)'(i)))) begin
                hit     = 1'b1;
                hit_idx = IDX_W'(i);
                data_ok = (data_q[i] == st_data);
                bit_set = map_q[i];
            end
        end
    end

endmodule

// File: rtl/store_check_monitor.sv
// Store-bus checker: matches CPU stores against an expected table, reports sticky pass/fail/timeout.
// Latency: verdict registered on the edge sampling the deciding store, visible the next cycle.
// Backpressure: none; passive tap of MemWrite/DataAdr/WriteData, never stalls the CPU.
//
// Ports: clk/reset (async active-low); cfg_* load the expected table outside
// RUN; start arms a run; mem_write/data_adr/write_data tap the CPU store
// port; busy/done/pass/fail/fail_code/fail_addr/match_cnt/store_cnt report status.
module store_check_monitor
    import store_check_pkg::*;
#(
    parameter int          ADDR_W  = 32,
    parameter int          DATA_W  = 32,
    parameter int          NUM_EXP = 4,
    parameter bit          ORDERED = 1'b1,
    parameter int unsigned IGN_LO  = 0,
    parameter int unsigned IGN_HI  = 99,
    parameter int          TIMEOUT = 4096,
    parameter int          IDX_W   = (NUM_EXP > 1) ? $clog2(NUM_EXP) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cfg_we,
    input  logic [IDX_W-1:0]  cfg_idx,
    input  logic [ADDR_W-1:0] cfg_addr,
    input  logic [DATA_W-1:0] cfg_data,
    input  logic              start,
    input  logic              mem_write,
    input  logic [ADDR_W-1:0] data_adr,
    input  logic [DATA_W-1:0] write_data,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic              fail,
    output logic [1:0]        fail_code,
    output logic [ADDR_W-1:0] fail_addr,
    output logic [IDX_W:0]    match_cnt,
    output logic [15:0]       store_cnt
);

    localparam int CYC_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [ADDR_W-1:0] IGN_LO_A  = ADDR_W'(IGN_LO);
    localparam logic [ADDR_W-1:0] IGN_SPAN  = ADDR_W'(IGN_HI) - ADDR_W'(IGN_LO);
    localparam logic [CYC_W-1:0]  CYC_LAST  = CYC_W'(TIMEOUT - 1);
    localparam logic [IDX_W:0]    MATCH_FIN = (IDX_W+1)'(NUM_EXP - 1);

    state_e             state_q, state_d;
    logic [CYC_W-1:0]   cyc_q, cyc_d;
    logic [15:0]        store_cnt_q, store_cnt_d;
    logic [IDX_W:0]     match_cnt_q, match_cnt_d;
    logic [1:0]         fail_code_q, fail_code_d;
    logic [ADDR_W-1:0]  fail_addr_q, fail_addr_d;

    logic               hit, data_ok, bit_set;
    logic [IDX_W-1:0]   hit_idx;
    logic               arm, st_vld, in_ign;
    logic               st_match, st_dfail, st_afail, st_final, tmo;

    // A start pulse is only honoured outside RUN; the table is only writable there too.
    assign arm    = start && (state_q != ST_RUN);
    assign st_vld = (state_q == ST_RUN) && mem_write;

    // Single unsigned compare on the offset covers both window bounds.
    assign in_ign = ((data_adr - IGN_LO_A) <= IGN_SPAN);

    assign st_match = hit && data_ok && (ORDERED || !bit_set);
    assign st_dfail = hit && !data_ok;
    assign st_afail = !hit && !in_ign;
    assign st_final = st_vld && st_match && (match_cnt_q == MATCH_FIN);
    assign tmo      = (state_q == ST_RUN) && (cyc_q == CYC_LAST);

    store_exp_table #(
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .NUM_EXP (NUM_EXP),
        .IDX_W   (IDX_W),
        .ORDERED (ORDERED)
    ) u_table (
        .clk     (clk),
        .rst_n   (reset),
        .wr_en   (cfg_we && (state_q != ST_RUN)),
        .wr_idx  (cfg_idx),
        .wr_addr (cfg_addr),
        .wr_data (cfg_data),
        .clr_map (arm),
        .set_en  (st_vld && st_match),
        .set_idx (hit_idx),
        .ord_idx (match_cnt_q),
        .st_addr (data_adr),
        .st_data (write_data),
        .hit     (hit),
        .hit_idx (hit_idx),
        .data_ok (data_ok),
        .bit_set (bit_set)
    );

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: the final match beats a same-cycle timeout, and a store
    // failure beats it as well.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN: begin
                if (st_final) begin
                    state_d = ST_PASS;
                end else if (st_vld && (st_dfail || st_afail)) begin
                    state_d = ST_FAIL;
                end else if (tmo) begin
                    state_d = ST_FAIL;
                end
            end
            default: begin
                if (start) begin
                    state_d = ST_RUN;
                end
            end
        endcase
    end

    // Outputs derived from state; verdict flags are sticky because the
    // state holds in PASS/FAIL until start or reset.
    always_comb begin
        busy      = (state_q == ST_RUN);
        pass      = (state_q == ST_PASS);
        fail      = (state_q == ST_FAIL);
        done      = (state_q == ST_PASS) || (state_q == ST_FAIL);
        fail_code = fail_code_q;
        fail_addr = fail_addr_q;
        match_cnt = match_cnt_q;
        store_cnt = store_cnt_q;
    end

    // Counter and verdict-detail next state.
    always_comb begin
        cyc_d       = cyc_q;
        store_cnt_d = store_cnt_q;
        match_cnt_d = match_cnt_q;
        fail_code_d = fail_code_q;
        fail_addr_d = fail_addr_q;
        if (arm) begin
            cyc_d       = '0;
            store_cnt_d = '0;
            match_cnt_d = '0;
            fail_code_d = FC_NONE;
            fail_addr_d = '0;
        end else if (state_q == ST_RUN) begin
            cyc_d = cyc_q + 1'b1;
            if (st_vld && (store_cnt_q != 16'hFFFF)) begin
                store_cnt_d = store_cnt_q + 16'd1;
            end
            if (st_vld && st_match) begin
                match_cnt_d = match_cnt_q + 1'b1;
            end
            if (st_vld && st_dfail) begin
                fail_code_d = FC_DATA;
                fail_addr_d = data_adr;
            end else if (st_vld && st_afail) begin
                fail_code_d = FC_ADDR;
                fail_addr_d = data_adr;
            end else if (tmo && !st_final) begin
                fail_code_d = FC_TIMEOUT;
                fail_addr_d = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cyc_q       <= '0;
            store_cnt_q <= '0;
            match_cnt_q <= '0;
            fail_code_q <= FC_NONE;
            fail_addr_q <= '0;
        end else begin
            cyc_q       <= cyc_d;
            store_cnt_q <= store_cnt_d;
            match_cnt_q <= match_cnt_d;
            fail_code_q <= fail_code_d;
            fail_addr_q <= fail_addr_d;
        end
    end

endmodule
